// File: rtl/sw_result_collector.sv
// sw_result_collector: consumes the SmithWaterman per-target result stream,
// tracks the best target and the target count of each query independently,
// cross-checks them against the core's own report, and queues one summary
// record per finished query for a host on a valid/ready interface.

`ifndef CALC_BIT
`define CALC_BIT 16
`endif
`ifndef MAX_T_NUM_BIT
`define MAX_T_NUM_BIT 8
`endif

module sw_result_collector #(
  parameter int CALC_W     = `CALC_BIT,
  parameter int TIDX_W     = `MAX_T_NUM_BIT,
  parameter int QIDX_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              res_valid_i,
  input  logic [CALC_W-1:0] result_i,
  input  logic              change_q_i,
  input  logic [TIDX_W-1:0] match_idx_i,
  input  logic [CALC_W-1:0] max_result_i,
  output logic              rec_valid_o,
  input  logic              rec_ready_i,
  output logic [QIDX_W-1:0] rec_q_idx_o,
  output logic [TIDX_W-1:0] rec_t_idx_o,
  output logic [CALC_W-1:0] rec_score_o,
  output logic [TIDX_W:0]   rec_t_cnt_o,
  output logic              rec_mismatch_o,
  output logic              overflow_o,
  output logic [QIDX_W-1:0] q_done_o
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  localparam logic [1:0] ST_EMPTY   = 2'd0;
  localparam logic [1:0] ST_PARTIAL = 2'd1;
  localparam logic [1:0] ST_FULL    = 2'd2;

  localparam logic [TIDX_W:0] CNT_MAX = '1;

  // Per-query accumulators
  logic [TIDX_W:0]   t_cnt;
  logic [CALC_W-1:0] best_score;
  logic [TIDX_W-1:0] best_idx;
  logic [QIDX_W-1:0] q_idx;
  logic [QIDX_W-1:0] q_done;
  logic              overflow;

  // Record FIFO
  logic [QIDX_W-1:0] mem_q     [FIFO_DEPTH];
  logic [TIDX_W-1:0] mem_t     [FIFO_DEPTH];
  logic [CALC_W-1:0] mem_s     [FIFO_DEPTH];
  logic [TIDX_W:0]   mem_c     [FIFO_DEPTH];
  logic              mem_m     [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr, wr_inc, rd_inc;
  logic [1:0]        state, state_nxt;

  // Combinational datapath
  logic              beat, close, take, pop, push_ok, drop, head_valid;
  logic [CALC_W-1:0] nxt_score;
  logic [TIDX_W-1:0] nxt_idx;
  logic [TIDX_W:0]   cnt_inc;
  logic              mismatch;

  // Running-best compare, saturating count and push/pop qualification
  always_comb begin
    beat       = res_valid_i & ~start_i;
    close      = beat & change_q_i;
    take       = (t_cnt == '0) || (result_i > best_score);
    nxt_score  = take ? result_i : best_score;
    nxt_idx    = take ? t_cnt[TIDX_W-1:0] : best_idx;
    cnt_inc    = (t_cnt == CNT_MAX) ? t_cnt : t_cnt + 1'b1;
    mismatch   = (nxt_idx != match_idx_i) || (nxt_score != max_result_i);
    head_valid = (state != ST_EMPTY);
    pop        = head_valid & rec_ready_i & ~start_i;
    push_ok    = close & ((state != ST_FULL) | pop);
    drop       = close & (state == ST_FULL) & ~pop;
    wr_inc     = wr_ptr + 1'b1;
    rd_inc     = rd_ptr + 1'b1;
  end

  // FIFO occupancy state transitions
  always_comb begin
    state_nxt = state;
    case (state)
      ST_EMPTY:   if (push_ok) state_nxt = ST_PARTIAL;
      ST_PARTIAL: begin
        if (push_ok && !pop && (wr_inc == rd_ptr))     state_nxt = ST_FULL;
        else if (pop && !push_ok && (rd_inc == wr_ptr)) state_nxt = ST_EMPTY;
      end
      ST_FULL:    if (pop && !push_ok) state_nxt = ST_PARTIAL;
      default:    state_nxt = ST_EMPTY;
    endcase
  end

  // FIFO control: state, pointers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_EMPTY;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (start_i) begin
      state  <= ST_EMPTY;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      state <= state_nxt;
      if (push_ok) wr_ptr <= wr_inc;
      if (pop)     rd_ptr <= rd_inc;
    end
  end

  // FIFO storage; contents are only observed through the valid-gated outputs
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr] <= q_idx;
      mem_t[wr_ptr] <= nxt_idx;
      mem_s[wr_ptr] <= nxt_score;
      mem_c[wr_ptr] <= cnt_inc;
      mem_m[wr_ptr] <= mismatch;
    end
  end

  // Per-query accumulation and query bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t_cnt      <= '0;
      best_score <= '0;
      best_idx   <= '0;
      q_idx      <= '0;
      q_done     <= '0;
      overflow   <= 1'b0;
    end else if (start_i) begin
      t_cnt      <= '0;
      best_score <= '0;
      best_idx   <= '0;
      q_idx      <= '0;
      q_done     <= '0;
      overflow   <= 1'b0;
    end else begin
      if (drop) overflow <= 1'b1;
      if (close) begin
        t_cnt      <= '0;
        best_score <= '0;
        best_idx   <= '0;
        q_idx      <= q_idx + 1'b1;
        if (q_done != '1) q_done <= q_done + 1'b1;
      end else if (beat) begin
        t_cnt      <= cnt_inc;
        best_score <= nxt_score;
        best_idx   <= nxt_idx;
      end
    end
  end

  // Head record presentation, forced to zero while the FIFO is empty
  always_comb begin
    rec_valid_o    = head_valid;
    rec_q_idx_o    = '0;
    rec_t_idx_o    = '0;
    rec_score_o    = '0;
    rec_t_cnt_o    = '0;
    rec_mismatch_o = 1'b0;
    if (head_valid) begin
      rec_q_idx_o    = mem_q[rd_ptr];
      rec_t_idx_o    = mem_t[rd_ptr];
      rec_score_o    = mem_s[rd_ptr];
      rec_t_cnt_o    = mem_c[rd_ptr];
      rec_mismatch_o = mem_m[rd_ptr];
    end
    overflow_o = overflow;
    q_done_o   = q_done;
  end

endmodule

// File: tb/tb_sw_result_collector.sv
// Testbench for sw_result_collector: directed scenarios followed by random
// queries, every cycle compared against a queue-based reference model.

module tb_sw_result_collector;

  localparam int CW = 8;
  localparam int TW = 4;
  localparam int QW = 8;
  localparam int D  = 4;
  localparam int SATMAX = (1 << (TW + 1)) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_i = 1'b0;
  logic          res_valid_i = 1'b0;
  logic [CW-1:0] result_i = '0;
  logic          change_q_i = 1'b0;
  logic [TW-1:0] match_idx_i = '0;
  logic [CW-1:0] max_result_i = '0;
  logic          rec_valid_o;
  logic          rec_ready_i = 1'b0;
  logic [QW-1:0] rec_q_idx_o;
  logic [TW-1:0] rec_t_idx_o;
  logic [CW-1:0] rec_score_o;
  logic [TW:0]   rec_t_cnt_o;
  logic          rec_mismatch_o;
  logic          overflow_o;
  logic [QW-1:0] q_done_o;

  sw_result_collector #(
    .CALC_W(CW), .TIDX_W(TW), .QIDX_W(QW), .FIFO_DEPTH(D)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i),
    .res_valid_i(res_valid_i), .result_i(result_i), .change_q_i(change_q_i),
    .match_idx_i(match_idx_i), .max_result_i(max_result_i),
    .rec_valid_o(rec_valid_o), .rec_ready_i(rec_ready_i),
    .rec_q_idx_o(rec_q_idx_o), .rec_t_idx_o(rec_t_idx_o),
    .rec_score_o(rec_score_o), .rec_t_cnt_o(rec_t_cnt_o),
    .rec_mismatch_o(rec_mismatch_o), .overflow_o(overflow_o),
    .q_done_o(q_done_o)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct { int q; int t; int s; int c; int m; } rec_t;
  rec_t mq[$];
  int   m_cnt, m_best, m_bidx, m_q, m_done;
  int   m_ovf;
  bit   rnd_ready = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    m_cnt = 0; m_best = 0; m_bidx = 0; m_q = 0; m_done = 0; m_ovf = 0;
  endtask

  // Applies the collector's rules to the inputs present at this edge.
  task automatic model_edge();
    rec_t r;
    int   c1;
    if (start_i) begin
      model_clear();
      return;
    end
    if (mq.size() > 0 && rec_ready_i) void'(mq.pop_front());
    if (res_valid_i) begin
      if (m_cnt == 0 || int'(result_i) > m_best) begin
        m_best = int'(result_i);
        m_bidx = m_cnt % (1 << TW);
      end
      c1 = (m_cnt + 1 > SATMAX) ? SATMAX : m_cnt + 1;
      if (change_q_i) begin
        r.q = m_q; r.t = m_bidx; r.s = m_best; r.c = c1;
        r.m = (m_bidx != int'(match_idx_i)) || (m_best != int'(max_result_i));
        if (mq.size() < D) mq.push_back(r);
        else m_ovf = 1;
        m_q = (m_q + 1) % (1 << QW);
        if (m_done < (1 << QW) - 1) m_done++;
        m_cnt = 0; m_best = 0; m_bidx = 0;
      end else begin
        m_cnt = c1;
      end
    end
  endtask

  task automatic check_outputs();
    chk("rec_valid", rec_valid_o, mq.size() > 0);
    if (mq.size() > 0) begin
      chk("rec_q_idx", rec_q_idx_o, mq[0].q);
      chk("rec_t_idx", rec_t_idx_o, mq[0].t);
      chk("rec_score", rec_score_o, mq[0].s);
      chk("rec_t_cnt", rec_t_cnt_o, mq[0].c);
      chk("rec_mismatch", rec_mismatch_o, mq[0].m);
    end
    chk("overflow", overflow_o, m_ovf);
    chk("q_done", q_done_o, m_done);
  endtask

  task automatic step();
    if (rnd_ready) rec_ready_i = ($urandom % 3) != 0;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic beat(int score, bit last, int mi, int mr);
    res_valid_i  = 1'b1;
    result_i     = CW'(score);
    change_q_i   = last;
    match_idx_i  = TW'(mi);
    max_result_i = CW'(mr);
    step();
    res_valid_i  = 1'b0;
    change_q_i   = 1'b0;
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    step();
    start_i = 1'b0;
  endtask

  // Random-score query of n beats; the closing report is either the true
  // best (honest) or a random guess.
  task automatic run_query(int n, bit honest, bit gaps);
    int s, pt, ps;
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        int g = $urandom_range(0, 2);
        for (int k = 0; k < g; k++) step();
      end
      s = $urandom_range(0, 15);
      if (i == n - 1) begin
        if (m_cnt == 0 || s > m_best) begin pt = m_cnt % (1 << TW); ps = s; end
        else begin pt = m_bidx; ps = m_best; end
        if (!honest) begin pt = $urandom_range(0, 15); ps = $urandom_range(0, 15); end
        beat(s, 1'b1, pt, ps);
      end else begin
        beat(s, 1'b0, 0, 0);
      end
    end
  endtask

  initial begin
    int occ;
    model_clear();

    // Reset state
    #2;
    chk("reset_valid", rec_valid_o, 0);
    chk("reset_overflow", overflow_o, 0);
    chk("reset_q_done", q_done_o, 0);
    chk("reset_q_idx", rec_q_idx_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // 4-beat query, core agrees
    beat(5, 0, 0, 0);
    beat(9, 0, 0, 0);
    beat(9, 0, 0, 0);
    chk("q1_not_yet_valid", rec_valid_o, 0);
    beat(3, 1, 1, 9);
    chk("q1_valid", rec_valid_o, 1);
    chk("q1_q", rec_q_idx_o, 0);
    chk("q1_t", rec_t_idx_o, 1);
    chk("q1_s", rec_score_o, 9);
    chk("q1_c", rec_t_cnt_o, 4);
    chk("q1_m", rec_mismatch_o, 0);
    rec_ready_i = 1'b1; step(); rec_ready_i = 1'b0;

    // Same query, core reports a different index
    beat(5, 0, 0, 0); beat(9, 0, 0, 0); beat(9, 0, 0, 0); beat(3, 1, 2, 9);
    chk("q2_m", rec_mismatch_o, 1);
    chk("q2_t", rec_t_idx_o, 1);
    rec_ready_i = 1'b1; step(); rec_ready_i = 1'b0;

    // Single-beat queries
    pulse_start();
    beat(0, 1, 0, 0);
    chk("single_c", rec_t_cnt_o, 1);
    chk("single_t", rec_t_idx_o, 0);
    chk("single_s", rec_score_o, 0);
    chk("single_m", rec_mismatch_o, 0);
    rec_ready_i = 1'b1;
    beat(4, 1, 0, 4);
    rec_ready_i = 1'b0;
    chk("single_next_q", rec_q_idx_o, 1);
    rec_ready_i = 1'b1; step(); rec_ready_i = 1'b0;

    // Overflow: five records into a four-deep FIFO
    pulse_start();
    for (int i = 0; i < 5; i++) run_query(2, 1'b1, 1'b0);
    chk("ovf_flag", overflow_o, 1);
    chk("ovf_q_done", q_done_o, 5);
    for (int k = 0; k < 4; k++) begin
      chk("ovf_drain_q", rec_q_idx_o, k);
      rec_ready_i = 1'b1;
      step();
    end
    rec_ready_i = 1'b0;
    chk("ovf_drained", rec_valid_o, 0);
    chk("ovf_sticky", overflow_o, 1);

    // FIFO full, closing beat coincides with pop
    pulse_start();
    for (int i = 0; i < 4; i++) run_query(1, 1'b1, 1'b0);
    rec_ready_i = 1'b1;
    beat(7, 1, 0, 7);
    rec_ready_i = 1'b0;
    chk("fullpop_ovf", overflow_o, 0);
    chk("fullpop_head", rec_q_idx_o, 1);
    occ = 0;
    rec_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (rec_valid_o) occ++;
      step();
    end
    rec_ready_i = 1'b0;
    chk("fullpop_occupancy", occ, 4);

    // Asynchronous reset mid-query
    run_query(2, 1'b1, 1'b0);
    beat(4, 0, 0, 0);
    beat(6, 0, 0, 0);
    #2 rst_n = 1'b0;
    model_clear();
    #1;
    chk("midrst_valid", rec_valid_o, 0);
    chk("midrst_q_done", q_done_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    beat(2, 0, 0, 0); beat(8, 0, 0, 0); beat(1, 1, 1, 8);
    chk("midrst_q", rec_q_idx_o, 0);
    chk("midrst_c", rec_t_cnt_o, 3);
    chk("midrst_t", rec_t_idx_o, 1);
    rec_ready_i = 1'b1; step(); rec_ready_i = 1'b0;
    chk("midrst_single_rec", rec_valid_o, 0);

    // start_i mid-query with a discarded simultaneous beat
    beat(3, 0, 0, 0);
    beat(5, 0, 0, 0);
    start_i = 1'b1;
    beat(200, 1, 0, 200);
    start_i = 1'b0;
    chk("start_discard", rec_valid_o, 0);
    beat(1, 0, 0, 0); beat(2, 0, 0, 0); beat(9, 1, 2, 9);
    chk("start_q", rec_q_idx_o, 0);
    chk("start_c", rec_t_cnt_o, 3);
    chk("start_t", rec_t_idx_o, 2);
    chk("start_m", rec_mismatch_o, 0);
    rec_ready_i = 1'b1; step(); rec_ready_i = 1'b0;

    // Target count saturation: 40 rising scores
    pulse_start();
    for (int i = 0; i < 39; i++) beat(i, 0, 0, 0);
    beat(39, 1, 15, 39);
    chk("sat_c", rec_t_cnt_o, SATMAX);
    chk("sat_t", rec_t_idx_o, SATMAX % (1 << TW));
    chk("sat_s", rec_score_o, 39);
    chk("sat_m", rec_mismatch_o, 0);
    rec_ready_i = 1'b1; step(); rec_ready_i = 1'b0;

    // Random queries with random host backpressure and occasional restarts
    pulse_start();
    rnd_ready = 1;
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 40) == 0) pulse_start();
      run_query($urandom_range(1, 6), $urandom_range(0, 1), 1'b1);
    end
    rnd_ready = 0;
    rec_ready_i = 1'b1;
    for (int i = 0; i < 6; i++) step();
    chk("final_empty", rec_valid_o, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/sw_result_collector.md
Name: sw_result_collector

Overview:
- Sits directly downstream of SmithWaterman and consumes its per-target result stream (valid_o, result_o, change_q_o, match_idx_o, max_result_o).
- Independently tracks the best target per query and counts targets per query.
- Cross-checks its own best against the core's reported match_idx/max_result.
- Queues one summary record per finished query in a small FIFO, drained by a host through a valid/ready handshake.

Parameters:
- CALC_W, default `CALC_BIT: score width.
- TIDX_W, default `MAX_T_NUM_BIT: target index width.
- QIDX_W, default 8: query counter width.
- FIFO_DEPTH, default 4: record FIFO entries; must be a power of two, at least 2.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start_i  in  1  synchronous clear of all state; pulsed alongside the core start.
- res_valid_i  in  1  result beat from core valid_o.
- result_i  in  CALC_W  score of current target.
- change_q_i  in  1  beat is the last target of the current query.
- match_idx_i  in  TIDX_W  core-reported best target; sampled only on a change_q beat.
- max_result_i  in  CALC_W  core-reported best score; sampled only on a change_q beat.
- rec_valid_o  out  1  FIFO head valid.
- rec_ready_i  in  1  host accepts head.
- rec_q_idx_o  out  QIDX_W  query number, starting at 0.
- rec_t_idx_o  out  TIDX_W  collector's best target index.
- rec_score_o  out  CALC_W  collector's best score.
- rec_t_cnt_o  out  TIDX_W+1  number of targets seen in the query.
- rec_mismatch_o  out  1  collector best differs from core report.
- overflow_o  out  1  sticky: a record was dropped.
- q_done_o  out  QIDX_W  queries completed (saturating).

Behaviour:
- Reset (rst_n=0, async): all outputs 0, FIFO empty, accumulators cleared.
- Accumulator registers: t_cnt, best_score, best_idx, q_idx.
- Ordinary beat (res_valid_i=1, change_q_i=0):
  - If t_cnt==0 or result_i > best_score (strict, earliest index wins ties): best_score<=result_i, best_idx<=t_cnt.
  - t_cnt<=t_cnt+1.
- Closing beat (res_valid_i=1, change_q_i=1):
  - Apply the same compare to this final beat.
  - Form record {q_idx, final best_idx, final best_score, t_cnt+1, mismatch}.
  - mismatch = (final best_idx != match_idx_i) OR (final best_score != max_result_i).
  - Push the record; clear t_cnt/best; q_idx<=q_idx+1 (wraps); q_done_o increments, saturating at all-ones.
- Latency: the record is written at the closing-beat edge. If the FIFO was empty, rec_valid_o=1 in the following cycle with that record on the rec_* outputs.
- Handshake:
  - Head pops on a rising edge with rec_valid_o&rec_ready_i.
  - rec_* outputs stay stable while rec_valid_o=1 and rec_ready_i=0.
  - rec_ready_i is ignored when the FIFO is empty.
- FIFO states: EMPTY / PARTIAL / FULL, with pointers wrapping modulo FIFO_DEPTH.
  - Push while FULL and no pop in the same cycle: record dropped, overflow_o<=1 and held until reset or start_i.
  - Push and pop in the same cycle while FULL: both accepted, occupancy unchanged, no overflow.
  - Push and pop in the same cycle while EMPTY cannot occur (no head).
- t_cnt saturation: t_cnt saturates at 2^(TIDX_W+1)-1; further beats are counted no further, but the compare still runs using the saturated index.
- start_i=1:
  - Clears FIFO, accumulators, q_idx, q_done_o and overflow_o at the next edge.
  - Any simultaneous res_valid_i beat is discarded.
  - Any simultaneous pop is irrelevant.
- Reset mid-query: partial accumulation is lost and no record is emitted.
- res_valid_i=0: inputs are ignored entirely, including change_q_i.

Test Plan:
- Query of 4 beats with scores 5,9,9,3 and core reporting idx1/9 -> one record: q0, t_idx1, score9, cnt4, mismatch0; rec_valid_o rises the cycle after beat 4.
- Same query but core reports idx2/9 -> record mismatch=1, t_idx1.
- Single-beat query (change_q on first beat, score 0, core idx0/0) -> record cnt1, t_idx0, score0, mismatch0; next query record has q_idx1.
- rec_ready_i held 0 through 5 closing beats with FIFO_DEPTH=4 -> 4 records retained (q0..q3), overflow_o=1, q_done_o=5. Then raise rec_ready_i -> q0..q3 drain in order, one per cycle.
- FIFO full, closing beat coincides with pop -> record q4 accepted, overflow_o stays 0, occupancy stays 4.
- Mid-query (2 beats in) assert rst_n=0 asynchronously, then run a 3-beat query -> only one record with q0, cnt3. Repeat using start_i instead of reset, with a res_valid_i beat in the start_i cycle -> that beat is not counted.
